// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: next-PC select encodings, reset constants,
// and the branch-offset helper used by the next-PC calculator.
package fetch_stage_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'd0,
        NPC_BEQ = 3'd1,
        NPC_BNE = 3'd2,
        NPC_J   = 3'd3,
        NPC_JR  = 3'd4
    } npc_op_e;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Word offset sign-extended and scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC select. Branch and jump targets are formed from pc_id,
// the PC of the control-transfer instruction sitting in ID.
module fetch_stage_npc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_if,
    input  logic [31:0] pc_id,
    input  logic [2:0]  npc_op,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] w_seq;
    logic [31:0] w_btarg;
    logic [31:0] w_jtarg;

    assign w_seq   = pc_if + 32'd4;
    assign w_btarg = pc_id + 32'd4 + branch_offset(imm16);
    assign w_jtarg = {pc_id[31:28], instr_index, 2'b00};

    always_comb begin
        next_pc = w_seq;
        case (npc_op)
            NPC_BEQ: next_pc = zero ? w_btarg : w_seq;
            NPC_BNE: next_pc = zero ? w_seq : w_btarg;
            NPC_J:   next_pc = w_jtarg;
            NPC_JR:  next_pc = jr_target;
            default: next_pc = w_seq;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register and IF/ID pipeline register. The delay slot is
// architectural, so a redirect only changes the fetch after the slot; there is no flush.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_if,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc8_id,
    output logic        adel_if
);

    logic [31:0] r_pc_if;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc_id;
    logic [31:0] w_next_pc;

    fetch_stage_npc u_npc (
        .pc_if       (r_pc_if),
        .pc_id       (r_pc_id),
        .npc_op      (npc_op),
        .zero        (zero),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .next_pc     (w_next_pc)
    );

    // Reset wins over stall so a pending branch in ID is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_if    <= RESET_PC;
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= RESET_PC;
        end else if (!stall) begin
            r_pc_if    <= w_next_pc;
            r_instr_id <= instr_in;
            r_pc_id    <= r_pc_if;
        end
    end

    assign pc_if    = r_pc_if;
    assign instr_id = r_instr_id;
    assign pc_id    = r_pc_id;
    assign pc8_id   = r_pc_id + 32'd8;
    assign adel_if  = (r_pc_if[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, branches, jumps, stall, misalignment and wrap.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_op;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] instr_in;
    logic [31:0] pc_if;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic [31:0] pc8_id;
    logic        adel_if;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IM_KEY = 32'hDEAD_BEEF;

    fetch_stage #(
        .RESET_PC  (32'h0000_3000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_op      (npc_op),
        .zero        (zero),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .instr_in    (instr_in),
        .pc_if       (pc_if),
        .instr_id    (instr_id),
        .pc_id       (pc_id),
        .pc8_id      (pc8_id),
        .adel_if     (adel_if)
    );

    // Combinational instruction memory: contents are a fixed function of the address.
    assign instr_in = pc_if ^ IM_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e_pc_if,
                              input logic [31:0] e_pc_id, input logic [31:0] e_instr);
        check({tag, ".pc_if"},    pc_if,    e_pc_if);
        check({tag, ".pc_id"},    pc_id,    e_pc_id);
        check({tag, ".instr_id"}, instr_id, e_instr);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b1; npc_op = 3'd0; zero = 1'b0;
        imm16 = '0; instr_index = '0; jr_target = '0;

        // 1: reset with stall asserted
        step(); step();
        check_regs("rst", 32'h3000, 32'h3000, 32'h0);
        check("rst.pc8", pc8_id, 32'h3008);
        check("rst.adel", {31'd0, adel_if}, 32'd0);
        reset = 1'b0; stall = 1'b0;
        step();
        check_regs("seq1", 32'h3004, 32'h3000, 32'h3000 ^ IM_KEY);
        step();
        check_regs("seq2", 32'h3008, 32'h3004, 32'h3004 ^ IM_KEY);
        step();
        check_regs("seq3", 32'h300C, 32'h3008, 32'h3008 ^ IM_KEY);

        // 2: BEQ taken backwards (0x3008 + 4 - 8), then not taken
        npc_op = 3'd1; zero = 1'b1; imm16 = 16'hFFFE;
        step();
        check_regs("beq_t", 32'h3004, 32'h300C, 32'h300C ^ IM_KEY);
        zero = 1'b0;
        step();
        check_regs("beq_nt", 32'h3008, 32'h3004, 32'h3004 ^ IM_KEY);

        // 3: BNE taken from pc_id=0x3010, then not taken
        npc_op = 3'd0;
        step(); step(); step();
        check_regs("seq4", 32'h3014, 32'h3010, 32'h3010 ^ IM_KEY);
        check("bne.pc8", pc8_id, 32'h3018);
        npc_op = 3'd2; zero = 1'b0; imm16 = 16'h0003;
        step();
        check_regs("bne_t", 32'h3020, 32'h3014, 32'h3014 ^ IM_KEY);
        zero = 1'b1;
        step();
        check_regs("bne_nt", 32'h3024, 32'h3020, 32'h3020 ^ IM_KEY);

        // 4: J from pc_id=0x3000; delay-slot instruction reaches ID
        npc_op = 3'd0; reset = 1'b1;
        step();
        reset = 1'b0;
        check_regs("rst2", 32'h3000, 32'h3000, 32'h0);
        npc_op = 3'd3; instr_index = 26'h0000C10;
        step();
        check_regs("j", 32'h3040, 32'h3000, 32'h3000 ^ IM_KEY);
        npc_op = 3'd0;
        step();
        check_regs("j_next", 32'h3044, 32'h3040, 32'h3040 ^ IM_KEY);

        // 5: stall three cycles while JR is decoded
        stall = 1'b1; npc_op = 3'd4; jr_target = 32'h4000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_regs("stall", 32'h3044, 32'h3040, 32'h3040 ^ IM_KEY);
        end
        stall = 1'b0;
        step();
        check_regs("jr", 32'h4000, 32'h3044, 32'h3044 ^ IM_KEY);

        // 6: misaligned JR target, then reset together with stall
        jr_target = 32'h3002;
        step();
        check_regs("jr_mis", 32'h3002, 32'h4000, 32'h4000 ^ IM_KEY);
        check("adel", {31'd0, adel_if}, 32'd1);
        reset = 1'b1; stall = 1'b1;
        step();
        check_regs("rst_stall", 32'h3000, 32'h3000, 32'h0);
        check("rst_stall.adel", {31'd0, adel_if}, 32'd0);
        reset = 1'b0; stall = 1'b0;

        // Wrap at top of address space, jump using pc_id upper nibble, undefined op as SEQ
        jr_target = 32'hFFFF_FFFC;
        step();
        check_regs("jr_top", 32'hFFFF_FFFC, 32'h3000, 32'h3000 ^ IM_KEY);
        npc_op = 3'd0;
        step();
        check_regs("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ IM_KEY);
        check("wrap.pc8", pc8_id, 32'h0000_0004);
        npc_op = 3'd3; instr_index = 26'h0000001;
        step();
        check_regs("j_hi", 32'hF000_0004, 32'h0000_0000, 32'h0000_0000 ^ IM_KEY);
        npc_op = 3'd6;
        step();
        check_regs("op6", 32'hF000_0008, 32'hF000_0004, 32'hF000_0004 ^ IM_KEY);
        check("op6.pc8", pc8_id, 32'hF000_000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
